// File: rtl/dual_slope_counter_if.sv
// Control/status bundle between the dual-slope ADC control FSM (master) and the
// timing/count datapath (slave).
interface dual_slope_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable_counting;
  logic             counter_clear;
  logic             load;
  logic             comparator;
  logic             finished_counting;
  logic             cap_discharged;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             overflow;

  modport master (
    output enable_counting, counter_clear, load, comparator,
    input  finished_counting, cap_discharged, result, result_valid, overflow
  );

  modport slave (
    input  enable_counting, counter_clear, load, comparator,
    output finished_counting, cap_discharged, result, result_valid, overflow
  );
endinterface

// File: rtl/dual_slope_counter.sv
// Dual-slope ADC timing and count datapath: times the integration window, counts the
// de-integration interval, synchronises the comparator and holds the conversion result.
module dual_slope_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned T_INT       = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  dual_slope_counter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIntegrate, StDeintegrate, StDone} state_e;

  localparam logic [WIDTH-1:0] CountMax = '1;
  localparam logic [WIDTH-1:0] IntLast  = WIDTH'(T_INT - 1);

  state_e                 r_state, w_state_d;
  logic [WIDTH-1:0]       r_count, w_count_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_finished, w_finished_d;
  logic                   r_cap, w_cap_d;
  logic [WIDTH-1:0]       r_result, w_result_d;
  logic                   r_result_valid, w_result_valid_d;
  logic                   r_overflow, w_overflow_d;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_count        <= '0;
      r_sync         <= '0;
      r_finished     <= 1'b0;
      r_cap          <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_count        <= w_count_d;
      r_sync         <= {r_sync[SYNC_STAGES-2:0], bus.comparator};
      r_finished     <= w_finished_d;
      r_cap          <= w_cap_d;
      r_result       <= w_result_d;
      r_result_valid <= w_result_valid_d;
      r_overflow     <= w_overflow_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (bus.counter_clear) begin
      w_state_d = StIdle;
    end else if (bus.load && (r_state == StDeintegrate)) begin
      w_state_d = StDone;
    end else begin
      unique case (r_state)
        StIdle:      if (bus.enable_counting) w_state_d = StIntegrate;
        StIntegrate: begin
          if (!bus.enable_counting)    w_state_d = StIdle;
          else if (r_count == IntLast) w_state_d = StDeintegrate;
        end
        default:     w_state_d = r_state;
      endcase
    end
  end

  always_comb begin
    w_count_d        = r_count;
    w_finished_d     = 1'b0;
    w_result_d       = r_result;
    w_result_valid_d = r_result_valid;
    w_overflow_d     = r_overflow;
    // Gating on the next state keeps the flag low from the very edge that leaves DEINTEGRATE.
    w_cap_d          = w_sync_out && (w_state_d == StDeintegrate);
    if (bus.counter_clear) begin
      w_count_d    = '0;
      w_overflow_d = 1'b0;
    end else if (bus.load && (r_state == StDeintegrate)) begin
      w_result_d       = r_count;
      w_result_valid_d = 1'b1;
    end else begin
      unique case (r_state)
        StIdle:      w_count_d = bus.enable_counting ? WIDTH'(1) : '0;
        StIntegrate: begin
          if (!bus.enable_counting || (r_count == IntLast)) begin
            w_count_d = '0;
          end else begin
            w_count_d = r_count + 1'b1;
          end
          w_finished_d = bus.enable_counting && (r_count == IntLast);
        end
        StDeintegrate: begin
          if (bus.enable_counting) begin
            if (r_count != CountMax) w_count_d = r_count + 1'b1;
            if ((r_count + 1'b1) == CountMax || r_count == CountMax) w_overflow_d = 1'b1;
          end
        end
        default:     w_count_d = r_count;
      endcase
    end
  end

  assign bus.finished_counting = r_finished;
  assign bus.cap_discharged    = r_cap;
  assign bus.result            = r_result;
  assign bus.result_valid      = r_result_valid;
  assign bus.overflow          = r_overflow;

endmodule
